// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg
//   Shared constants for the input conditioner: default parameter values,
//   symbolic channel indices and the debounce counter width helper.
package input_conditioner_pkg;

  localparam int N_CH_DEF            = 4;
  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 16;

  // Channel assignment used by the default four-channel build.
  localparam int CH_RESET  = 0;
  localparam int CH_WALK   = 1;
  localparam int CH_REPROG = 2;
  localparam int CH_SENSOR = 3;

  // Debounce counter width: max(1, clog2(cycles)). The counter only has to
  // reach cycles-1, so clog2 bits are enough; one cycle still needs one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/input_conditioner_ch.sv
// input_conditioner_ch
//   One conditioner channel: synchronizer chain, debounce counter, edge
//   pulses and a sticky request flag.
//   Ports:
//     clk         system clock, rising edge
//     reset       synchronous active-high reset
//     raw_in      asynchronous external input
//     clear_in    acknowledge that clears req_latched
//     level_out   synchronized, debounced level
//     rise_pulse  one-cycle pulse on an accepted 0->1 change of level_out
//     fall_pulse  one-cycle pulse on an accepted 1->0 change of level_out
//     req_latched sticky flag set by rise_pulse, cleared by clear_in
module input_conditioner_ch
  import input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  input  logic clear_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic req_latched
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   req_q, req_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // Plain shift chain: nothing between stages so each flop gets a full
  // cycle to resolve metastability.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    req_d   = req_q;

    if (sync == level_q) begin
      // Any return to the accepted level restarts the qualification window.
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      // New level has held long enough: accept it and emit the edge pulse
      // on the same edge level_out changes.
      cnt_d   = '0;
      level_d = sync;
      rise_d  = sync;
      fall_d  = ~sync;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // Set has priority over a coincident clear.
    if (rise_d) begin
      req_d = 1'b1;
    end else if (clear_in) begin
      req_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      req_q   <= req_d;
    end
  end

  assign level_out   = level_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign req_latched = req_q;

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner
//   N_CH independent input conditioning channels (synchronize, debounce,
//   edge-detect, latch requests). Pure structural wrapper.
//   Ports:
//     clk         system clock, rising edge
//     reset       synchronous active-high reset
//     raw_in      [N_CH] asynchronous external inputs
//     clear_in    [N_CH] per-channel request acknowledge
//     level_out   [N_CH] debounced levels
//     rise_pulse  [N_CH] accepted 0->1 pulses
//     fall_pulse  [N_CH] accepted 1->0 pulses
//     req_latched [N_CH] sticky request flags
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int N_CH            = N_CH_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] raw_in,
  input  logic [N_CH-1:0] clear_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] req_latched
);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    input_conditioner_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .raw_in     (raw_in[gi]),
      .clear_in   (clear_in[gi]),
      .level_out  (level_out[gi]),
      .rise_pulse (rise_pulse[gi]),
      .fall_pulse (fall_pulse[gi]),
      .req_latched(req_latched[gi])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;
  import input_conditioner_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] raw_a, clr_a, lvl_a, rise_a, fall_a, req_a;
  logic [3:0] raw_b, clr_b, lvl_b, rise_b, fall_b, req_b;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Main build: 4 channels, 2 sync stages, 4 debounce cycles.
  input_conditioner #(.N_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) u_dut_a (
    .clk(clk), .reset(reset), .raw_in(raw_a), .clear_in(clr_a),
    .level_out(lvl_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .req_latched(req_a)
  );

  // Corner build: 3 sync stages, no debounce filtering.
  input_conditioner #(.N_CH(4), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) u_dut_b (
    .clk(clk), .reset(reset), .raw_in(raw_b), .clear_in(clr_b),
    .level_out(lvl_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .req_latched(req_b)
  );

  typedef struct {
    logic       rst;
    logic [3:0] raw;
    logic [3:0] clr;
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] req;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(input logic [3:0] raw, input logic [3:0] clr,
                              input logic [3:0] lvl, input logic [3:0] rise,
                              input logic [3:0] fall, input logic [3:0] req);
    vec_t v;
    v.rst = 1'b0; v.raw = raw; v.clr = clr;
    v.lvl = lvl; v.rise = rise; v.fall = fall; v.req = req;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int e, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s edge %0d: got %b expected %b", nm, e, act, exp);
  endtask

  // Two reset edges, then edge 1 is the next rising edge.
  task automatic do_reset();
    reset = 1'b1; raw_a = '0; clr_a = '0; raw_b = '0; clr_b = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    // Rows indexed from edge 1: inputs are applied before the edge,
    // outputs are expected just after it.
    tbl[0]  = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[1]  = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[2]  = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[3]  = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[4]  = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[5]  = mk(4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0010); // edge 6 rise
    tbl[6]  = mk(4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    tbl[7]  = mk(4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000); // clear alone
    tbl[8]  = mk(4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    tbl[9]  = mk(4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    tbl[10] = mk(4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    tbl[11] = mk(4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    tbl[12] = mk(4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    tbl[13] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000); // edge 14 fall
    tbl[14] = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[15] = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[16] = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[17] = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[18] = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[19] = mk(4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010); // set wins over clear
    tbl[20] = mk(4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000); // clear next cycle
    tbl[21] = mk(4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000); // clear while 0: no-op

    // Reset state
    do_reset();
    chk("rst_lvl", 0, lvl_a, 4'b0000);
    chk("rst_rise", 0, rise_a, 4'b0000);
    chk("rst_fall", 0, fall_a, 4'b0000);
    chk("rst_req", 0, req_a, 4'b0000);

    // Walk request rise, clear handling, fall and second rise
    for (int k = 0; k < 22; k++) begin
      reset = tbl[k].rst; raw_a = tbl[k].raw; clr_a = tbl[k].clr;
      tick();
      $display("row %0d: raw=%b clr=%b -> lvl=%b rise=%b fall=%b req=%b",
               k + 1, tbl[k].raw, tbl[k].clr, lvl_a, rise_a, fall_a, req_a);
      chk("tbl_lvl", k + 1, lvl_a, tbl[k].lvl);
      chk("tbl_rise", k + 1, rise_a, tbl[k].rise);
      chk("tbl_fall", k + 1, fall_a, tbl[k].fall);
      chk("tbl_req", k + 1, req_a, tbl[k].req);
    end

    // Sensor glitch of 3 cycles must be filtered
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      raw_a = (e <= 3) ? 4'b1000 : 4'b0000;
      tick();
      chk("glitch_lvl", e, {3'b000, lvl_a[CH_SENSOR]}, 4'b0000);
      chk("glitch_rise", e, {3'b000, rise_a[CH_SENSOR]}, 4'b0000);
      chk("glitch_fall", e, {3'b000, fall_a[CH_SENSOR]}, 4'b0000);
    end
    $display("seq glitch done");

    // Reset driven after edge 4 (sampled at edge 5) while walk is held high;
    // qualification restarts and the rise lands at edge 11.
    do_reset();
    raw_a = 4'b0010;
    for (int e = 1; e <= 12; e++) begin
      reset = (e == 5);
      tick();
      chk("rstmid_lvl", e, lvl_a, (e >= 11) ? 4'b0010 : 4'b0000);
      chk("rstmid_rise", e, rise_a, (e == 11) ? 4'b0010 : 4'b0000);
      chk("rstmid_fall", e, fall_a, 4'b0000);
      chk("rstmid_req", e, req_a, (e >= 11) ? 4'b0010 : 4'b0000);
    end
    reset = 1'b0;
    $display("seq reset-mid-debounce done");

    // All channels settle high, then all drop together
    do_reset();
    raw_a = 4'b1111;
    for (int e = 1; e <= 6; e++) tick();
    chk("all_hi_lvl", 6, lvl_a, 4'b1111);
    chk("all_hi_req", 6, req_a, 4'b1111);
    raw_a = 4'b0000;
    for (int e = 7; e <= 13; e++) begin
      tick();
      chk("all_lo_lvl", e, lvl_a, (e >= 12) ? 4'b0000 : 4'b1111);
      chk("all_lo_fall", e, fall_a, (e == 12) ? 4'b1111 : 4'b0000);
      chk("all_lo_rise", e, rise_a, 4'b0000);
      chk("all_lo_req", e, req_a, 4'b1111);
    end
    $display("seq all-fall done");

    // One-cycle debounce, 3-stage sync: single-cycle pulse passes through
    do_reset();
    for (int e = 1; e <= 7; e++) begin
      raw_b = (e == 1) ? 4'b0001 : 4'b0000;
      tick();
      chk("d1_lvl", e, {3'b000, lvl_b[CH_RESET]}, (e == 4) ? 4'b0001 : 4'b0000);
      chk("d1_rise", e, {3'b000, rise_b[CH_RESET]}, (e == 4) ? 4'b0001 : 4'b0000);
      chk("d1_fall", e, {3'b000, fall_b[CH_RESET]}, (e == 5) ? 4'b0001 : 4'b0000);
    end
    $display("seq debounce-1 done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter N_CH, default 4: number of independent input channels (reset request, walk request, reprogram, sensor); legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: flip-flop depth of each synchronizer chain; legal range 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16: consecutive cycles a new synced level must hold before acceptance; legal range 1..65535.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-006 raw_in  input  N_CH  asynchronous external inputs, one bit per channel.
REQ-007 clear_in  input  N_CH  per-channel acknowledge that clears req_latched.
REQ-008 level_out  output  N_CH  synchronized, debounced level.
REQ-009 rise_pulse  output  N_CH  one-cycle pulse on each accepted 0->1 transition of level_out.
REQ-010 fall_pulse  output  N_CH  one-cycle pulse on each accepted 1->0 transition of level_out.
REQ-011 req_latched  output  N_CH  sticky request flag; set by rise_pulse, cleared by clear_in.

Function
REQ-012 Each channel SHALL be fully independent; no output bit depends on another channel's inputs.
REQ-013 raw_in[i] SHALL pass through a SYNC_STAGES-deep register chain; the last stage is sync[i], and no logic SHALL sit between stages.
REQ-014 Each channel SHALL hold a debounce counter of width max(1, clog2(DEBOUNCE_CYCLES)), unsigned.
REQ-015 When sync[i] == level_out[i], the counter SHALL load 0.
REQ-016 When sync[i] != level_out[i] and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-017 When sync[i] != level_out[i] and counter == DEBOUNCE_CYCLES-1, level_out[i] SHALL take sync[i] on that edge and the counter SHALL load 0.
REQ-018 The counter SHALL never wrap; it SHALL be bounded by REQ-017.
REQ-019 Latency SHALL be SYNC_STAGES + DEBOUNCE_CYCLES edges from the first edge sampling a stable new raw level to the level_out change.
REQ-020 A level held on sync for fewer than DEBOUNCE_CYCLES consecutive cycles SHALL NOT change level_out.
REQ-021 rise_pulse[i] and fall_pulse[i] SHALL be registered, asserted on the same edge that level_out[i] changes, and deasserted on the next edge; the two pulses are never high together.
REQ-022 req_latched[i] SHALL set on the same edge that rise_pulse[i] asserts.
REQ-023 When clear_in[i] is high and no set occurs on that edge, req_latched[i] SHALL clear on that edge.
REQ-024 If set and clear_in[i] coincide on one edge, req_latched[i] SHALL be 1 (set wins).
REQ-025 clear_in[i] high while req_latched[i] = 0 with no set SHALL be a no-op.
REQ-026 With DEBOUNCE_CYCLES = 1, level_out[i] SHALL follow sync[i] with exactly one edge of delay.

Reset
REQ-027 While reset is high at an edge, all synchronizer stages, counters, level_out, rise_pulse, fall_pulse and req_latched SHALL load 0.
REQ-028 Reset asserted mid-debounce SHALL discard the partial count; no pulse SHALL be emitted on the reset edge or on the first edge after reset deasserts.
REQ-029 After reset deasserts, a raw_in held at 1 SHALL produce level_out = 1 and one rise_pulse, SYNC_STAGES + DEBOUNCE_CYCLES edges later.

Structure
REQ-030 The shared package input_conditioner_pkg SHALL hold the default constants, channel index constants (CH_RESET=0, CH_WALK=1, CH_REPROG=2, CH_SENSOR=3) and the counter-width function.
REQ-031 The per-channel logic SHALL live in a sub-module input_conditioner_ch, instantiated N_CH times by a generate loop.
REQ-032 The top level SHALL contain no logic other than the instances.

Verification (N_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4 unless noted)
REQ-033 raw_in[1] 0->1 before edge 1, then held -> level_out[1]=1 and rise_pulse[1]=1 at edge 6 only, req_latched[1]=1 from edge 6.
REQ-034 raw_in[3] high for exactly 3 cycles, then low -> level_out[3], rise_pulse[3] and fall_pulse[3] stay 0 throughout.
REQ-035 clear_in[1] pulsed on the same edge as a new rise_pulse[1] -> req_latched[1] stays 1; clear_in[1] pulsed alone one cycle later -> req_latched[1]=0 next edge.
REQ-036 reset high at edge 4 of scenario REQ-033 for 1 cycle -> all outputs 0, then rise_pulse[1] at edge 4+1+6 = edge 11 (raw still held high).
REQ-037 All 4 channels toggled 1->0 on the same cycle after settling -> four simultaneous fall_pulse bits, level_out=4'b0000, req_latched unchanged.
REQ-038 DEBOUNCE_CYCLES=1, SYNC_STAGES=3, single-cycle raw_in[0] pulse -> level_out[0] high for exactly 1 cycle at edge 4, with rise_pulse[0] at edge 4 and fall_pulse[0] at edge 5.
